// File: rtl/mux2_arbiter_pkg.sv
// Shared definitions for the two-requester mux select arbiter:
// FSM state encoding and mux select constants.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for two requesters sharing a 2:1 mux.
// Drives registered grants and the mux select. A holder that keeps the
// grant for MAX_HOLD cycles while the other side waits is preempted.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last_a,
    input  logic i_last_b,
    output logic o_gnt_a,
    output logic o_gnt_b,
    output logic o_sel,
    output logic o_busy,
    output logic o_preempt
);

    // Counter value seen in the holder's final allowed cycle, and the saturation value.
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [CW-1:0] hold_cnt;
    logic          ptr_b;        // 1: B wins the next simultaneous request
    logic          sel;
    logic          preempt;
    logic          preempt_nxt;
    logic          timeout;
    logic          entering;

    assign timeout  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign entering = (state_nxt != state) && (state_nxt != IDLE);

    // Next-state decision: release beats timeout; a handoff never passes through IDLE.
    always_comb begin
        state_nxt   = state;
        preempt_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req_a && (!i_req_b || !ptr_b)) begin
                    state_nxt = GNT_A;
                end else if (i_req_b) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A: begin
                if (i_last_a || !i_req_a) begin
                    state_nxt = i_req_b ? GNT_B : IDLE;
                end else if (timeout && i_req_b) begin
                    state_nxt   = GNT_B;
                    preempt_nxt = 1'b1;
                end
            end
            GNT_B: begin
                if (i_last_b || !i_req_b) begin
                    state_nxt = i_req_a ? GNT_A : IDLE;
                end else if (timeout && i_req_a) begin
                    state_nxt   = GNT_A;
                    preempt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold counter, round-robin pointer, select and preempt pulse; all update on grant entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt <= '0;
            ptr_b    <= 1'b0;
            sel      <= SEL_A;
            preempt  <= 1'b0;
        end else begin
            preempt <= preempt_nxt;
            if (entering) begin
                hold_cnt <= '0;
                ptr_b    <= (state_nxt == GNT_A);
                sel      <= (state_nxt == GNT_B) ? SEL_B : SEL_A;
            end else if ((state != IDLE) && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign o_gnt_a   = (state == GNT_A);
    assign o_gnt_b   = (state == GNT_B);
    assign o_busy    = (state != IDLE);
    assign o_sel     = sel;
    assign o_preempt = preempt;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus random
// traffic, compared every cycle against an ownership/tenure model.
module tb_mux2_arbiter;

    localparam int unsigned TB_MAX_HOLD = 4;
    localparam int unsigned TB_CW       = 3;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_req_a = 1'b0, i_req_b = 1'b0, i_last_a = 1'b0, i_last_b = 1'b0;
    logic o_gnt_a, o_gnt_b, o_sel, o_busy, o_preempt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the mux, for how long, who wins the next tie.
    int owner  = 0;   // 0 nobody, 1 A, 2 B
    int tenure = 0;   // cycles since the current grant began, unbounded
    bit prio_b = 1'b0;
    bit m_sel  = 1'b0;
    bit m_pre  = 1'b0;

    mux2_arbiter #(.MAX_HOLD(TB_MAX_HOLD), .CW(TB_CW)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req_a  (i_req_a),
        .i_req_b  (i_req_b),
        .i_last_a (i_last_a),
        .i_last_b (i_last_b),
        .o_gnt_a  (o_gnt_a),
        .o_gnt_b  (o_gnt_b),
        .o_sel    (o_sel),
        .o_busy   (o_busy),
        .o_preempt(o_preempt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = 0;
        tenure = 0;
        prio_b = 1'b0;
        m_sel  = 1'b0;
        m_pre  = 1'b0;
    endtask

    // One arbitration decision from the rules: release first, then timeout, then idle pick.
    task automatic model_step(input bit ra, input bit rb, input bit la, input bit lb);
        int  nxt;
        bit  hreq, hlast, oreq;
        nxt   = owner;
        m_pre = 1'b0;
        if (owner == 0) begin
            if (ra && rb) nxt = prio_b ? 2 : 1;
            else if (ra)  nxt = 1;
            else if (rb)  nxt = 2;
        end else begin
            hreq  = (owner == 1) ? ra : rb;
            hlast = (owner == 1) ? la : lb;
            oreq  = (owner == 1) ? rb : ra;
            if (hlast || !hreq) begin
                nxt = oreq ? 3 - owner : 0;
            end else if (TB_MAX_HOLD > 0 && tenure == int'(TB_MAX_HOLD) - 1 && oreq) begin
                nxt   = 3 - owner;
                m_pre = 1'b1;
            end
        end
        if (nxt != 0 && nxt != owner) begin
            tenure = 0;
            prio_b = (nxt == 1);
            m_sel  = (nxt == 2);
        end else if (nxt != 0) begin
            tenure++;
        end
        owner = nxt;
    endtask

    task automatic compare_all();
        check("gnt_a",   o_gnt_a,   owner == 1);
        check("gnt_b",   o_gnt_b,   owner == 2);
        check("busy",    o_busy,    owner != 0);
        check("sel",     o_sel,     m_sel);
        check("preempt", o_preempt, m_pre);
    endtask

    task automatic step(input bit ra, input bit rb, input bit la, input bit lb);
        i_req_a  = ra;
        i_req_b  = rb;
        i_last_a = la;
        i_last_b = lb;
        @(posedge i_clk);
        model_step(ra, rb, la, lb);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        i_req_a = 0; i_req_b = 0; i_last_a = 0; i_last_b = 0;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        bit ra, rb;

        // Reset values, then single request A with release by i_last_a.
        do_reset();
        step(1, 0, 0, 0);
        check("single_gnt_a", o_gnt_a, 1);
        check("single_sel",   o_sel,   0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("single_idle", o_busy, 0);

        // Simultaneous requests: round-robin A, B, A.
        do_reset();
        step(1, 1, 0, 0);
        check("rr_first_a", o_gnt_a, 1);
        step(1, 1, 1, 0);
        check("rr_then_b", o_gnt_b, 1);
        check("rr_sel_b",  o_sel,   1);
        step(1, 1, 0, 1);
        check("rr_again_a", o_gnt_a, 1);

        // Preemption: grant moves to B four cycles after A's grant, one pulse.
        do_reset();
        step(1, 0, 0, 0);
        pulses = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            if (o_preempt) pulses++;
        end
        check("pre_moved_b", o_gnt_b, 1);
        for (int unsigned i = 0; i < 2; i++) begin
            step(0, 1, 0, 0);
            if (o_preempt) pulses++;
        end
        check("pre_one_pulse", pulses, 1);

        // No preemption while the other side is idle; saturated holder keeps the grant.
        do_reset();
        step(1, 0, 0, 0);
        for (int unsigned i = 0; i < 20; i++) step(1, 0, 0, 0);
        check("hold_gnt_a", o_gnt_a, 1);
        for (int unsigned i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("hold_sat_keep_a", o_gnt_a, 1);

        // Release coinciding with timeout: handoff without preempt pulse.
        do_reset();
        step(1, 1, 0, 0);
        for (int unsigned i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        check("relto_gnt_b",   o_gnt_b,   1);
        check("relto_no_pre",  o_preempt, 0);

        // Asynchronous reset while B holds: grant and select clear before the next edge.
        do_reset();
        step(0, 1, 0, 0);
        check("mid_gnt_b", o_gnt_b, 1);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_gnt_b", o_gnt_b, 0);
        check("mid_rst_sel",   o_sel,   0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(1, 1, 0, 0);
        check("mid_prio_a", o_gnt_a, 1);

        // Random traffic.
        do_reset();
        for (int unsigned i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 7) != 0);
            rb = ($urandom_range(0, 7) != 0);
            step(ra, rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            check("never_both", o_gnt_a & o_gnt_b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles one requester holds the grant while the other waits; 0 disables preemption.
REQ-002 SHALL have parameter CW, default 5, meaning the hold-counter width; CW SHALL be at least clog2(MAX_HOLD+1).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports i_req_a and i_req_b, input, 1 bit each: requests for mux input A (select 0) and input B (select 1).
REQ-006 SHALL have ports i_last_a and i_last_b, input, 1 bit each: the holder's final cycle of use, valid only while its grant is high.
REQ-007 SHALL have ports o_gnt_a and o_gnt_b, output, 1 bit each: registered grants, never both high.
REQ-008 SHALL have port o_sel, output, 1 bit: registered select driving the 2:1 mux i_SEL.
REQ-009 SHALL have port o_busy, output, 1 bit: high while either grant is high.
REQ-010 SHALL have port o_preempt, output, 1 bit: one-cycle pulse when a grant is forcibly moved by timeout.

Function
REQ-011 SHALL implement FSM states IDLE, GNT_A and GNT_B; o_gnt_a=1 only in GNT_A and o_gnt_b=1 only in GNT_B.
REQ-012 SHALL, in IDLE with a single request, enter the matching GNT state next cycle, giving a request-to-grant latency of 1 cycle.
REQ-013 SHALL, in IDLE with both requests, grant the requester indicated by the priority pointer.
REQ-014 SHALL, on every grant, set the pointer to the requester that was not granted, making arbitration round-robin.
REQ-015 SHALL treat a release as the holder asserting i_last_x, or deasserting i_req_x, while granted.
REQ-016 SHALL, on release with the other requester asserting, move directly to the other GNT state next cycle, with no IDLE cycle and no overlapping grants.
REQ-017 SHALL, on release with the other requester idle, return to IDLE next cycle.
REQ-018 SHALL set o_sel to 0 on entering GNT_A and to 1 on entering GNT_B, changing in the same cycle as the grant.
REQ-019 SHALL hold the last o_sel value in IDLE.
REQ-020 SHALL clear the hold counter on entry to a GNT state and increment it every cycle in that state, saturating at MAX_HOLD.
REQ-021 SHALL, when MAX_HOLD>0, the counter equals MAX_HOLD-1 and the other request is high, switch the grant to the other requester next cycle and pulse o_preempt for that cycle.
REQ-022 SHALL keep the grant when the timeout is reached but the other requester is idle; the holder retains the grant indefinitely and the counter saturates.
REQ-023 SHALL give release precedence over preemption when both occur in the same cycle, with no o_preempt pulse.
REQ-024 SHALL never assert a grant for a requester whose i_req is low in the cycle the grant decision is made.

Reset
REQ-025 SHALL, on i_rst_n low, immediately set state IDLE, o_gnt_a=0, o_gnt_b=0, o_sel=0, o_busy=0, o_preempt=0, counter 0 and pointer A.
REQ-026 SHALL, when reset is asserted mid-grant, drop the grant asynchronously with no completion cycle.
REQ-027 SHALL make the first grant decision at the first rising edge after i_rst_n deassertion.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10) and the select constants SEL_A=0 and SEL_B=1 in the shared pipeline definitions package.
REQ-029 SHALL remain a single module with no sub-module; the hold counter is inline logic.
REQ-030 SHALL NOT instantiate the mux; it drives the mux select externally.

Verification
REQ-031 SHALL cover single request: i_req_a=1 at cycle 0 -> o_gnt_a=1 and o_sel=0 at cycle 1; i_last_a at cycle 3 -> o_gnt_a=0 and IDLE at cycle 4.
REQ-032 SHALL cover simultaneous requests after reset: both requests high -> A granted first; A releases -> B granted next cycle with o_sel=1; repeat -> A granted again, confirming round-robin.
REQ-033 SHALL cover preemption: MAX_HOLD=4, A holds without i_last and B requests -> grant moves to B 4 cycles after A's grant, o_preempt pulses exactly once.
REQ-034 SHALL cover no-preempt: MAX_HOLD=4, A holds 20 cycles with B idle -> o_gnt_a stays 1 and o_preempt stays 0.
REQ-035 SHALL cover simultaneous release and timeout: i_last_a in the timeout cycle with B requesting -> B granted next cycle and o_preempt=0.
REQ-036 SHALL cover reset mid-grant: i_rst_n low while o_gnt_b=1 -> o_gnt_b=0 and o_sel=0 before the next clock edge; after release A has priority.
